// File: rtl/ula_arb_pkg.sv
// Shared types and constants for the ULA arbiter slice.
package ula_arb_pkg;

  localparam int ULA_W  = 8;
  localparam int S_W    = 4;
  localparam int STAT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [ULA_W-1:0] a;
    logic [ULA_W-1:0] b;
    logic [S_W-1:0]   s;
    logic             m;
    logic             cin;
  } ula_op_t;

  // Function selects used by client blocks and benches.
  localparam logic [S_W-1:0] S_ADD  = 4'b1001;
  localparam logic           M_ADD  = 1'b0;
  localparam logic [S_W-1:0] S_AEQB = 4'b0000;
  localparam logic           M_AEQB = 1'b1;

endpackage

// File: rtl/ula_arbiter_if.sv
// Request, ULA and response channels of the ULA arbiter.
// slave = arbiter side, master = clients / ULA / consumer side.
interface ula_arbiter_if
  import ula_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) ();

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*ULA_W-1:0] req_a;
  logic [NREQ*ULA_W-1:0] req_b;
  logic [NREQ*S_W-1:0]   req_s;
  logic [NREQ-1:0]       req_m;
  logic [NREQ-1:0]       req_cin;

  logic [ULA_W-1:0]      ula_a;
  logic [ULA_W-1:0]      ula_b;
  logic [S_W-1:0]        ula_s;
  logic                  ula_m;
  logic                  ula_c_in;
  logic [ULA_W-1:0]      ula_f;
  logic                  ula_a_eq_b;
  logic                  ula_c_out;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [ULA_W-1:0]      rsp_f;
  logic                  rsp_a_eq_b;
  logic                  rsp_c_out;

  modport slave (
    input  req_valid, req_a, req_b, req_s, req_m, req_cin,
    input  ula_f, ula_a_eq_b, ula_c_out,
    input  rsp_ready,
    output req_ready,
    output ula_a, ula_b, ula_s, ula_m, ula_c_in,
    output rsp_valid, rsp_id, rsp_f, rsp_a_eq_b, rsp_c_out
  );

  modport master (
    output req_valid, req_a, req_b, req_s, req_m, req_cin,
    output ula_f, ula_a_eq_b, ula_c_out,
    output rsp_ready,
    input  req_ready,
    input  ula_a, ula_b, ula_s, ula_m, ula_c_in,
    input  rsp_valid, rsp_id, rsp_f, rsp_a_eq_b, rsp_c_out
  );

endinterface

// File: rtl/ula_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first set request strictly after ptr,
// wrapping modulo NREQ. One-hot grant plus encoded index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            any
);

  logic [IDW-1:0] sel;

  // Scan NREQ positions starting just after the last winner.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block can infer a latch.
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    sel      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sel = IDW'((int'(ptr) + k) % NREQ);
      if (!any && req[sel]) begin
        any         = 1'b1;
        grant[sel]  = 1'b1;
        grant_id    = sel;
      end
    end
  end

endmodule

// File: rtl/ula_arbiter.sv
// Shares one external ula_8_bits between NREQ requesters.
// IDLE: round-robin accept -> EXEC: ULA settles -> RESP: hold result until taken.
// Optional macro ULA_ARB_STATS_EN adds per-requester accept counters
// readable through stat_sel / stat_cnt.
module ula_arbiter
  import ula_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  ula_arbiter_if.slave       bus
`ifdef ULA_ARB_STATS_EN
  ,
  input  logic [IDW-1:0]     stat_sel,
  output logic [STAT_W-1:0]  stat_cnt
`endif
);

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  id_q;
  ula_op_t         op_q;
  ula_op_t         op_sel;
  ula_op_t         ops [NREQ];

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            grant_any;
  logic            accept;

  logic [IDW-1:0]   rsp_id_q;
  logic [ULA_W-1:0] rsp_f_q;
  logic             rsp_eq_q;
  logic             rsp_cout_q;

  // Unpack the flat request buses into one op per requester.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign ops[g] = '{a:   bus.req_a[g*ULA_W +: ULA_W],
                      b:   bus.req_b[g*ULA_W +: ULA_W],
                      s:   bus.req_s[g*S_W +: S_W],
                      m:   bus.req_m[g],
                      cin: bus.req_cin[g]};
  end

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req      (bus.req_valid),
    .ptr      (ptr),
    .grant    (grant),
    .grant_id (grant_id),
    .any      (grant_any)
  );

  assign op_sel        = ops[grant_id];
  assign accept        = (state == IDLE) && grant_any;
  assign bus.req_ready = (state == IDLE) ? grant : '0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: one EXEC cycle per op, RESP waits for the consumer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any)     state_nxt = EXEC;
      EXEC:                       state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Latch the granted op onto the ULA inputs; they hold while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
      id_q <= '0;
      ptr  <= IDW'(NREQ - 1);
    end else if (accept) begin
      op_q <= op_sel;
      id_q <= grant_id;
      ptr  <= grant_id;
    end
  end

  assign bus.ula_a    = op_q.a;
  assign bus.ula_b    = op_q.b;
  assign bus.ula_s    = op_q.s;
  assign bus.ula_m    = op_q.m;
  assign bus.ula_c_in = op_q.cin;

  // Capture the settled ULA outputs at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id_q   <= '0;
      rsp_f_q    <= '0;
      rsp_eq_q   <= 1'b0;
      rsp_cout_q <= 1'b0;
    end else if (state == EXEC) begin
      rsp_id_q   <= id_q;
      rsp_f_q    <= bus.ula_f;
      rsp_eq_q   <= bus.ula_a_eq_b;
      rsp_cout_q <= bus.ula_c_out;
    end
  end

  // Valid is exactly the RESP state, so reset drops it immediately.
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_f      = rsp_f_q;
  assign bus.rsp_a_eq_b = rsp_eq_q;
  assign bus.rsp_c_out  = rsp_cout_q;

`ifdef ULA_ARB_STATS_EN
  logic [STAT_W-1:0] cnt [NREQ];

  // Saturating accept counter per requester.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this small counter bank is plain flops, so it can take the async reset; a RAM-mapped array could not.
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else if (accept && (cnt[grant_id] != '1)) begin
      cnt[grant_id] <= cnt[grant_id] + STAT_W'(1);
    end
  end

  assign stat_cnt = (int'(stat_sel) < NREQ) ? cnt[stat_sel] : '0;
`endif

endmodule

// File: tb/tb_ula_arbiter.sv
// Self-checking bench for ula_arbiter with a behavioural ULA model and a
// response scoreboard.
module tb_ula_arbiter;
  import ula_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [7:0]     f;
    logic           eq;
    logic           cout;
  } rsp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ula_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) intf ();

`ifdef ULA_ARB_STATS_EN
  logic [IDW-1:0] stat_sel;
  logic [15:0]    stat_cnt;
`endif

  ula_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (intf)
`ifdef ULA_ARB_STATS_EN
    ,
    .stat_sel (stat_sel),
    .stat_cnt (stat_cnt)
`endif
  );

  int   total  = 0;
  int   passed = 0;
  rsp_t sb_q[$];

  // Behavioural stand-in for ula_8_bits: returns {a_eq_b, c_out, f}.
  function automatic logic [9:0] ula_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] s, input logic m, input logic cin);
    logic [8:0] sum;
    logic [7:0] f;
    logic       co;
    sum = '0;
    if (m) begin
      case (s)
        4'b0000: f = ~a;
        4'b1011: f = a & b;
        4'b1110: f = a | b;
        4'b0110: f = a ^ b;
        default: f = a ^ {s, s};
      endcase
      co = 1'b0;
    end else begin
      case (s)
        4'b1001: sum = {1'b0, a} + {1'b0, b}  + {8'd0, cin};
        4'b0110: sum = {1'b0, a} + {1'b0, ~b} + {8'd0, cin};
        default: sum = {1'b0, a} + {1'b0, s, s} + {8'd0, cin};
      endcase
      f  = sum[7:0];
      co = sum[8];
    end
    return {(a == b), co, f};
  endfunction

  function automatic rsp_t exp_rsp(input int i, input logic [7:0] a, input logic [7:0] b,
                                   input logic [3:0] s, input logic m, input logic cin);
    rsp_t r;
    r.id = IDW'(i);
    {r.eq, r.cout, r.f} = ula_model(a, b, s, m, cin);
    return r;
  endfunction

  always_comb begin
    {intf.ula_a_eq_b, intf.ula_c_out, intf.ula_f} =
      ula_model(intf.ula_a, intf.ula_b, intf.ula_s, intf.ula_m, intf.ula_c_in);
  end

  // Scoreboard: every response handshake is compared against the oldest expectation.
  always @(negedge clk) begin
    rsp_t got, exp;
    if (rst_n && intf.rsp_valid === 1'b1 && intf.rsp_ready === 1'b1) begin
      got = {intf.rsp_id, intf.rsp_f, intf.rsp_a_eq_b, intf.rsp_c_out};
      total++;
      if (sb_q.size() == 0) begin
        $display("FAIL rsp_unexpected got id=%0d f=%h eq=%b c=%b, required no response",
                 got.id, got.f, got.eq, got.cout);
      end else begin
        exp = sb_q.pop_front();
        if (got !== exp)
          $display("FAIL rsp_data got id=%0d f=%h eq=%b c=%b, required id=%0d f=%h eq=%b c=%b",
                   got.id, got.f, got.eq, got.cout, exp.id, exp.f, exp.eq, exp.cout);
        else passed++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] s, input logic m, input logic cin);
    intf.req_a[8*i +: 8]   = a;
    intf.req_b[8*i +: 8]   = b;
    intf.req_s[4*i +: 4]   = s;
    intf.req_m[i]          = m;
    intf.req_cin[i]        = cin;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      done = (sb_q.size() == 0) && (intf.rsp_valid === 1'b0);
    end
    total++;
    if (done) passed++;
    else $display("FAIL %s_drain got %0d pending responses, required 0", name, sb_q.size());
  endtask

  task automatic issue_one(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] s, input logic m, input logic cin);
    bit hs;
    @(posedge clk); #1;
    set_op(i, a, b, s, m, cin);
    sb_q.push_back(exp_rsp(i, a, b, s, m, cin));
    intf.req_valid[i] = 1'b1;
    hs = 1'b0;
    for (int c = 0; c < 50 && !hs; c++) begin
      @(negedge clk);
      hs = (intf.req_ready[i] === 1'b1);
    end
    @(posedge clk); #1;
    intf.req_valid[i] = 1'b0;
    total++;
    if (hs) passed++;
    else $display("FAIL grant_timeout req=%0d got no req_ready, required grant within 50 cycles", i);
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (intf.rsp_valid === 1'b0) passed++;
    else $display("FAIL reset_rsp_valid got %b, required 0", intf.rsp_valid);
    total++;
    if ({intf.ula_a, intf.ula_b, intf.ula_s, intf.ula_m, intf.ula_c_in} === 22'd0) passed++;
    else $display("FAIL reset_ula got a=%h b=%h s=%b m=%b c=%b, required all 0",
                  intf.ula_a, intf.ula_b, intf.ula_s, intf.ula_m, intf.ula_c_in);
    total++;
    if ({intf.rsp_id, intf.rsp_f, intf.rsp_a_eq_b, intf.rsp_c_out} === 12'd0) passed++;
    else $display("FAIL reset_rsp got id=%0d f=%h, required 0", intf.rsp_id, intf.rsp_f);
    total++;
    if (intf.req_ready === 4'b0000) passed++;
    else $display("FAIL reset_req_ready got %b, required 0000", intf.req_ready);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (intf.req_ready === 4'b0000 && intf.rsp_valid === 1'b0) passed++;
    else $display("FAIL idle_no_req got req_ready=%b rsp_valid=%b, required 0000/0",
                  intf.req_ready, intf.rsp_valid);
  endtask

  task automatic test_single_op();
    bit hs;
    @(posedge clk); #1;
    set_op(0, 8'h0F, 8'h01, S_ADD, M_ADD, 1'b0);
    sb_q.push_back(exp_rsp(0, 8'h0F, 8'h01, S_ADD, M_ADD, 1'b0));
    intf.req_valid[0] = 1'b1;
    hs = 1'b0;
    for (int c = 0; c < 50 && !hs; c++) begin
      @(negedge clk);
      hs = (intf.req_ready !== 4'b0000);
    end
    total++;
    if (hs && intf.req_ready === 4'b0001) passed++;
    else $display("FAIL single_grant got req_ready=%b, required 0001", intf.req_ready);
    @(posedge clk); #1;
    intf.req_valid[0] = 1'b0;
    @(negedge clk);
    total++;
    if (intf.rsp_valid === 1'b0) passed++;
    else $display("FAIL single_exec_valid got %b, required 0", intf.rsp_valid);
    total++;
    if ({intf.ula_a, intf.ula_b, intf.ula_s, intf.ula_m, intf.ula_c_in} ===
        {8'h0F, 8'h01, S_ADD, M_ADD, 1'b0}) passed++;
    else $display("FAIL single_ula_inputs got a=%h b=%h s=%b m=%b c=%b, required 0f 01 1001 0 0",
                  intf.ula_a, intf.ula_b, intf.ula_s, intf.ula_m, intf.ula_c_in);
    total++;
    if (intf.req_ready === 4'b0000) passed++;
    else $display("FAIL single_exec_ready got %b, required 0000", intf.req_ready);
    @(negedge clk);
    total++;
    if (intf.rsp_valid === 1'b1) passed++;
    else $display("FAIL single_latency got rsp_valid=%b two cycles after accept, required 1",
                  intf.rsp_valid);
    wait_drain("single");
  endtask

  task automatic test_overflow();
    issue_one(2, 8'hFF, 8'h01, S_ADD, M_ADD, 1'b0);
    wait_drain("overflow");
  endtask

  task automatic test_round(input string name, input int order [NREQ], input bit same);
    logic [7:0] av [NREQ];
    logic [7:0] bv [NREQ];
    logic [3:0] sv [NREQ];
    logic       mv [NREQ];
    logic       cv [NREQ];
    int         got_n;
    int         gid;
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      if (same) begin
        av[i] = 8'hAA; bv[i] = 8'hAA; sv[i] = S_AEQB; mv[i] = M_AEQB; cv[i] = 1'b0;
      end else begin
        av[i] = 8'(8'h11 * i + 3); bv[i] = 8'(8'h20 + i); sv[i] = S_ADD; mv[i] = M_ADD;
        cv[i] = i[0];
      end
      set_op(i, av[i], bv[i], sv[i], mv[i], cv[i]);
    end
    for (int k = 0; k < NREQ; k++) begin
      sb_q.push_back(exp_rsp(order[k], av[order[k]], bv[order[k]], sv[order[k]],
                             mv[order[k]], cv[order[k]]));
    end
    intf.req_valid = '1;
    got_n = 0;
    for (int c = 0; c < 80 && got_n < NREQ; c++) begin
      @(negedge clk);
      if (intf.req_ready !== 4'b0000) begin
        gid = -1;
        for (int j = 0; j < NREQ; j++) if (intf.req_ready[j] === 1'b1) gid = j;
        total++;
        if ($onehot(intf.req_ready) && gid == order[got_n]) passed++;
        else $display("FAIL %s_grant[%0d] got req_ready=%b, required requester %0d",
                      name, got_n, intf.req_ready, order[got_n]);
        got_n++;
        @(posedge clk); #1;
        if (gid >= 0) intf.req_valid[gid] = 1'b0;
      end
    end
    if (got_n < NREQ) begin
      total++;
      $display("FAIL %s_grant_timeout got %0d grants, required %0d", name, got_n, NREQ);
    end
    intf.req_valid = '0;
    wait_drain(name);
  endtask

  task automatic test_all_four();
    int ord [NREQ];
    pulse_reset();
    ord = '{0, 1, 2, 3};
    test_round("rr_from_reset", ord, 1'b1);
    issue_one(1, 8'h33, 8'h44, S_ADD, M_ADD, 1'b1);
    wait_drain("ptr_to_1");
    ord = '{2, 3, 0, 1};
    test_round("rr_from_ptr1", ord, 1'b0);
  endtask

  task automatic test_back_to_back_backpressure();
    bit seen;
    @(posedge clk); #1;
    set_op(3, 8'h50, 8'h20, 4'b0110, 1'b0, 1'b1);
    set_op(0, 8'h3C, 8'hC3, 4'b1011, 1'b1, 1'b0);
    sb_q.push_back(exp_rsp(3, 8'h50, 8'h20, 4'b0110, 1'b0, 1'b1));
    sb_q.push_back(exp_rsp(0, 8'h3C, 8'hC3, 4'b1011, 1'b1, 1'b0));
    intf.rsp_ready = 1'b0;
    intf.req_valid = 4'b1001;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = (intf.rsp_valid === 1'b1);
    end
    total++;
    if (seen) passed++;
    else $display("FAIL bp_first_rsp got no rsp_valid, required one within 50 cycles");
    @(posedge clk); #1;
    intf.req_valid[3] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (sb_q.size() > 0 && intf.rsp_valid === 1'b1 &&
          {intf.rsp_id, intf.rsp_f, intf.rsp_a_eq_b, intf.rsp_c_out} === sb_q[0]) passed++;
      else $display("FAIL bp_hold[%0d] got valid=%b id=%0d f=%h, required held first response",
                    c, intf.rsp_valid, intf.rsp_id, intf.rsp_f);
      total++;
      if (intf.req_ready === 4'b0000) passed++;
      else $display("FAIL bp_no_grant[%0d] got req_ready=%b, required 0000", c, intf.req_ready);
    end
    @(posedge clk); #1;
    intf.rsp_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = (intf.req_ready[0] === 1'b1);
    end
    total++;
    if (seen) passed++;
    else $display("FAIL bp_second_grant got no req_ready[0], required grant after release");
    @(posedge clk); #1;
    intf.req_valid = '0;
    wait_drain("backpressure");
  endtask

  task automatic test_reset_exec();
    bit hs;
    @(posedge clk); #1;
    set_op(0, 8'h12, 8'h34, S_ADD, M_ADD, 1'b0);
    sb_q.push_back(exp_rsp(0, 8'h12, 8'h34, S_ADD, M_ADD, 1'b0));
    intf.req_valid[0] = 1'b1;
    hs = 1'b0;
    for (int c = 0; c < 50 && !hs; c++) begin
      @(negedge clk);
      hs = (intf.req_ready[0] === 1'b1);
    end
    @(posedge clk); #1;
    intf.req_valid[0] = 1'b0;
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    @(negedge clk);
    total++;
    if (hs && intf.rsp_valid === 1'b0) passed++;
    else $display("FAIL rst_exec_valid got hs=%b rsp_valid=%b, required 1/0", hs, intf.rsp_valid);
    total++;
    if ({intf.ula_a, intf.ula_b, intf.ula_s, intf.ula_m, intf.ula_c_in} === 22'd0) passed++;
    else $display("FAIL rst_exec_ula got a=%h b=%h, required 0", intf.ula_a, intf.ula_b);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (intf.rsp_valid === 1'b0) passed++;
      else $display("FAIL rst_no_rsp[%0d] got rsp_valid=%b, required 0", c, intf.rsp_valid);
    end
    @(posedge clk); #1;
    set_op(0, 8'h01, 8'h02, S_ADD, M_ADD, 1'b1);
    set_op(1, 8'h05, 8'h05, S_AEQB, M_AEQB, 1'b0);
    sb_q.push_back(exp_rsp(0, 8'h01, 8'h02, S_ADD, M_ADD, 1'b1));
    sb_q.push_back(exp_rsp(1, 8'h05, 8'h05, S_AEQB, M_AEQB, 1'b0));
    intf.req_valid = 4'b0011;
    hs = 1'b0;
    for (int c = 0; c < 50 && !hs; c++) begin
      @(negedge clk);
      hs = (intf.req_ready !== 4'b0000);
    end
    total++;
    if (hs && intf.req_ready === 4'b0001) passed++;
    else $display("FAIL rst_ptr_grant got req_ready=%b, required 0001", intf.req_ready);
    @(posedge clk); #1;
    intf.req_valid[0] = 1'b0;
    hs = 1'b0;
    for (int c = 0; c < 50 && !hs; c++) begin
      @(negedge clk);
      hs = (intf.req_ready[1] === 1'b1);
    end
    @(posedge clk); #1;
    intf.req_valid = '0;
    wait_drain("reset_exec");
  endtask

  task automatic test_random();
    int         i;
    logic [7:0] a, b;
    logic [3:0] s;
    logic       m, cin;
    for (int n = 0; n < 12; n++) begin
      i   = int'($urandom_range(0, NREQ - 1));
      a   = 8'($urandom);
      b   = 8'($urandom);
      s   = 4'($urandom);
      m   = 1'($urandom);
      cin = 1'($urandom);
      issue_one(i, a, b, s, m, cin);
      wait_drain("random");
    end
  endtask

`ifdef ULA_ARB_STATS_EN
  task automatic test_stats();
    pulse_reset();
    for (int n = 0; n < 3; n++) begin
      issue_one(1, 8'(n), 8'h01, S_ADD, M_ADD, 1'b0);
      wait_drain("stats");
    end
    stat_sel = 2'd1;
    @(negedge clk);
    total++;
    if (stat_cnt === 16'd3) passed++;
    else $display("FAIL stats_req1 got %0d, required 3", stat_cnt);
    stat_sel = 2'd0;
    @(negedge clk);
    total++;
    if (stat_cnt === 16'd0) passed++;
    else $display("FAIL stats_req0 got %0d, required 0", stat_cnt);
  endtask
`endif

  initial begin
    intf.req_valid = '0;
    intf.req_a     = '0;
    intf.req_b     = '0;
    intf.req_s     = '0;
    intf.req_m     = '0;
    intf.req_cin   = '0;
    intf.rsp_ready = 1'b1;
`ifdef ULA_ARB_STATS_EN
    stat_sel = '0;
`endif
    test_reset();
    test_single_op();
    test_overflow();
    test_all_four();
    test_back_to_back_backpressure();
    test_reset_exec();
    test_random();
`ifdef ULA_ARB_STATS_EN
    test_stats();
`endif
    total++;
    if (sb_q.size() == 0) passed++;
    else $display("FAIL scoreboard_empty got %0d outstanding, required 0", sb_q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ula_arbiter.md
Name: ula_arbiter

Overview:
Shares one ula_8_bits instance between NREQ independent requesters.
- Round-robin grant selects one requester.
- Its operation (A, B, S, M, Cin) is registered onto the ULA inputs for one execute cycle.
- The ULA outputs are captured and returned on a single response channel tagged with the requester index.
- Sits between client blocks and the combinational ULA datapath; the ULA itself is instantiated outside this block.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, $clog2(NREQ), width of requester index on response

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester operation valid
req_ready  out  NREQ  per-requester accept (one-hot or zero)
req_a  in  NREQ*8  operand A, requester i at [8i+7:8i]
req_b  in  NREQ*8  operand B, same packing
req_s  in  NREQ*4  function select S, requester i at [4i+3:4i]
req_m  in  NREQ  mode (1 = logic, 0 = arithmetic)
req_cin  in  NREQ  carry in
ula_a  out  8  to ula_8_bits .a
ula_b  out  8  to ula_8_bits .b
ula_s  out  4  to ula_8_bits .s
ula_m  out  1  to ula_8_bits .m
ula_c_in  out  1  to ula_8_bits .c_in
ula_f  in  8  from ula_8_bits .f
ula_a_eq_b  in  1  from ula_8_bits .a_eq_b
ula_c_out  in  1  from ula_8_bits .c_out
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_id  out  IDW  index of requester that issued the op
rsp_f  out  8  captured F
rsp_a_eq_b  out  1  captured A=B
rsp_c_out  out  1  captured carry out

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous assert, active low.
- Reset values:
  - State IDLE; rr pointer = NREQ-1, so requester 0 has top priority first.
  - ula_a/ula_b/ula_s = 0; ula_m = 0; ula_c_in = 0.
  - rsp_valid = 0; rsp_id/rsp_f/rsp_a_eq_b/rsp_c_out = 0; req_ready = 0.
- IDLE:
  - Grant = first asserted req_valid searching from ptr+1 upward, modulo NREQ.
  - req_ready[grant] = 1 combinationally while in IDLE; all other bits 0.
  - On handshake: register that requester's a/b/s/m/cin onto ula_*, store id, set ptr = grant, go to EXEC.
  - No valid requests: stay in IDLE; ula_* hold their last values.
- EXEC (exactly 1 cycle):
  - ula_* are stable from registers; the ULA settles combinationally.
  - At the clock edge, capture ula_f/ula_a_eq_b/ula_c_out into rsp_*, set rsp_valid = 1, go to RESP.
- RESP:
  - rsp_valid and all rsp_* held stable until rsp_ready = 1.
  - req_ready = 0 throughout.
  - On rsp_valid & rsp_ready: rsp_valid = 0 next cycle, go to IDLE.
- Latency and throughput: accept at edge t -> rsp_valid high after edge t+2. Minimum 3 cycles per op.
- Fairness: a continuously requesting client is granted at most once per NREQ grants while others request.
- Simultaneous requests from all NREQ with ptr = 1: grant order is 2, 3, ..., 0, 1.
- The arbiter performs no arithmetic. S/M/Cin pass through unmodified, so all 32 ULA functions are reachable.
- Reset asserted mid-operation (EXEC or RESP): the pending op is dropped, rsp_valid clears immediately, and there is no response after reset.
- A requester dropping req_valid without a handshake is legal; arbitration re-evaluates every IDLE cycle.

Optional Feature:
ULA_ARB_STATS_EN
- Defined:
  - Adds ports stat_sel (in, IDW) and stat_cnt (out, 16).
  - Per-requester 16-bit saturating counters increment on each accepted request; value 0xFFFF holds.
  - stat_cnt = counter[stat_sel], combinational read.
  - All counters reset to 0 by rst_n.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package ula_arb_pkg:
  - ULA_W = 8, S_W = 4.
  - State enum {IDLE, EXEC, RESP}.
  - Packed struct ula_op_t {a, b, s, m, cin}.
  - Named S constants used by benches: S_ADD = 4'b1001 with M=0; S_AEQB = 4'b0000 with M=1.
- Sub-module rr_arbiter: NREQ-wide round-robin grant from a request vector and pointer; combinational, one-hot output plus encoded index.

Test Plan:
- Single op, requester 0: A=0x0F, B=0x01, S=1001, M=0, Cin=0 -> rsp_valid 2 cycles after accept; rsp_id=0; rsp_f=0x10; rsp_c_out equals the ula_8_bits output for these inputs.
- Overflow via requester 2: A=0xFF, B=0x01, S=1001, M=0, Cin=0 -> rsp_f=0x00; rsp_id=2; carry matches the ULA model.
- All 4 requesters valid from reset, each with A=B=0xAA, S=0000, M=1 -> grants in order 0, 1, 2, 3; each rsp_a_eq_b=1; rsp_id sequence 0, 1, 2, 3.
- Backpressure: rsp_ready held 0 for 5 cycles after rsp_valid -> rsp_* stable; req_ready all 0; no second grant until the response handshake.
- rst_n pulsed low during EXEC -> rsp_valid stays 0; ula_* = 0; after release, requester 0 wins the next arbitration.
- With ULA_ARB_STATS_EN: 3 ops from requester 1, stat_sel=1 -> stat_cnt=3; stat_sel=0 -> 0.
